// File: rtl/balance_bcd.sv
// balance_bcd: serial double-dabble converter from the bank's binary balance
// to packed BCD digits plus a leading-zero blank mask for the digit renderer.
// One balance bit is consumed per clock; bcd/blank only move on the DONE edge,
// so the display never observes a half-converted value.
module balance_bcd #(
  parameter int WIDTH  = 27,
  parameter int DIGITS = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      balance,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     blank,
  output logic                  busy,
  output logic                  done
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [WIDTH-1:0]      last_bal_q, last_bal_d;
  logic                  have_last_q, have_last_d;
  logic [WIDTH-1:0]      sh_q, sh_d;
  logic [4*DIGITS-1:0]   work_q, work_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [4*DIGITS-1:0]   bcd_q, bcd_d;
  logic [DIGITS-1:0]     blank_q, blank_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [4*DIGITS-1:0]   adj_s;

  // Add 3 to every digit that is 5 or more, all digits evaluated in parallel.
  function automatic logic [4*DIGITS-1:0] dabble_adj(input logic [4*DIGITS-1:0] w);
    logic [4*DIGITS-1:0] r;
    logic [3:0]          d;
    r = w;
    for (int k = 0; k < DIGITS; k++) begin
      d = w[4*k +: 4];
      if (d >= 4'd5) begin
        r[4*k +: 4] = d + 4'd3;
      end else begin
        r[4*k +: 4] = d;
      end
    end
    return r;
  endfunction

  // Digit k is blanked when it and every more significant digit are zero;
  // the units digit always stays visible.
  function automatic logic [DIGITS-1:0] blank_mask(input logic [4*DIGITS-1:0] w);
    logic [DIGITS-1:0] m;
    logic              all_zero;
    m        = '0;
    all_zero = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      if (w[4*k +: 4] != 4'd0) begin
        all_zero = 1'b0;
      end else begin
        all_zero = all_zero;
      end
      m[k] = all_zero;
    end
    m[0] = 1'b0;
    return m;
  endfunction

  // Pre-shift correction of the work digits for the current shift step.
  always_comb begin
    adj_s = dabble_adj(work_q);
  end

  // Next-state and datapath updates for the IDLE/SHIFT/DONE sequencer.
  always_comb begin
    state_d     = state_q;
    last_bal_d  = last_bal_q;
    have_last_d = have_last_q;
    sh_d        = sh_q;
    work_d      = work_q;
    cnt_d       = cnt_q;
    bcd_d       = bcd_q;
    blank_d     = blank_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!have_last_q || (balance != last_bal_q)) begin
          last_bal_d  = balance;
          sh_d        = balance;
          work_d      = '0;
          cnt_d       = '0;
          busy_d      = 1'b1;
          have_last_d = 1'b1;
          state_d     = ST_SHIFT;
        end else begin
          state_d     = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        work_d = {adj_s[4*DIGITS-2:0], sh_q[WIDTH-1]};
        sh_d   = {sh_q[WIDTH-2:0], 1'b0};
        cnt_d  = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: begin
        bcd_d   = work_q;
        blank_d = blank_mask(work_q);
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any conversion in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      last_bal_q  <= '0;
      have_last_q <= 1'b0;
      sh_q        <= '0;
      work_q      <= '0;
      cnt_q       <= '0;
      bcd_q       <= '0;
      blank_q     <= BLANK_RST;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_bal_q  <= last_bal_d;
      have_last_q <= have_last_d;
      sh_q        <= sh_d;
      work_q      <= work_d;
      cnt_q       <= cnt_d;
      bcd_q       <= bcd_d;
      blank_q     <= blank_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bcd   = bcd_q;
  assign blank = blank_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_balance_bcd.sv
// tb_balance_bcd: directed test of balance_bcd against a decimal reference model.
module tb_balance_bcd;

  localparam int WIDTH  = 27;
  localparam int DIGITS = 9;

  logic                clk;
  logic                rst_n;
  logic [WIDTH-1:0]    balance;
  logic [4*DIGITS-1:0] bcd;
  logic [DIGITS-1:0]   blank;
  logic                busy;
  logic                done;

  int n_total;
  int n_bad;

  balance_bcd #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .balance (balance),
    .bcd     (bcd),
    .blank   (blank),
    .busy    (busy),
    .done    (done)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: integer-to-decimal digits, units first.
  function automatic logic [35:0] ref_bcd(input int unsigned v);
    logic [35:0] r;
    int unsigned x;
    r = 36'd0;
    x = v;
    for (int k = 0; k < 9; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Reference: blank every digit above the most significant nonzero one.
  function automatic logic [8:0] ref_blank(input int unsigned v);
    logic [8:0] m;
    int unsigned ndig;
    int unsigned x;
    ndig = 1;
    x = v / 10;
    while (x != 0) begin
      ndig++;
      x = x / 10;
    end
    m = 9'd0;
    for (int k = 1; k < 9; k++) begin
      m[k] = (k >= ndig);
    end
    return m;
  endfunction

  // Sample #1 after each edge until done is seen or the budget runs out.
  task automatic wait_done(input int limit, output int edges, output int busy_cnt);
    edges = 0;
    busy_cnt = 0;
    while (edges < limit) begin
      @(posedge clk);
      #1;
      edges++;
      if (busy) busy_cnt++;
      if (done) break;
    end
    if (!done) check_val("done_timeout", {63'd0, done}, 64'd1);
  endtask

  task automatic check_result(input string tag, input int unsigned v);
    check_val({tag, "_bcd"}, {28'd0, bcd}, {28'd0, ref_bcd(v)});
    check_val({tag, "_blank"}, {55'd0, blank}, {55'd0, ref_blank(v)});
  endtask

  initial begin
    int edges;
    int bc;
    int dones;
    int busy_after;
    n_total = 0;
    n_bad   = 0;

    // 1. Reset with 12345 waiting, then release.
    rst_n   = 1'b0;
    balance = 27'd12345;
    #22;
    check_val("rst_bcd", {28'd0, bcd}, 64'd0);
    check_val("rst_blank", {55'd0, blank}, {55'd0, 9'b111111110});
    check_val("rst_busy", {63'd0, busy}, 64'd0);
    check_val("rst_done", {63'd0, done}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_val("t1_busy_rise", {63'd0, busy}, 64'd1);
    check_val("t1_bcd_held", {28'd0, bcd}, 64'd0);
    wait_done(40, edges, bc);
    check_val("t1_latency", edges, 64'd28);
    check_val("t1_busy_len", bc + 1, 64'd28);
    check_result("t1", 12345);
    check_val("t1_blank_lit", {55'd0, blank}, {55'd0, 9'b111100000});
    @(posedge clk);
    #1;
    check_val("t1_done_drop", {63'd0, done}, 64'd0);

    // 2. Zero after reset.
    rst_n   = 1'b0;
    balance = 27'd0;
    #10;
    @(negedge clk);
    rst_n = 1'b1;
    wait_done(40, edges, bc);
    check_result("t2", 0);

    // 3. Maximum value.
    balance = 27'd134217727;
    wait_done(40, edges, bc);
    check_result("t3", 134217727);
    check_val("t3_lit", {28'd0, bcd}, {28'd0, 36'h134217727});

    // 4a. 500 -> 999 at cnt=10.
    balance = 27'd500;
    @(posedge clk);
    #1;
    repeat (10) @(posedge clk);
    #1;
    balance = 27'd999;
    wait_done(40, edges, bc);
    check_result("t4a_first", 500);
    @(posedge clk);
    #1;
    check_val("t4a_retrig_busy", {63'd0, busy}, 64'd1);
    wait_done(40, edges, bc);
    check_result("t4a_second", 999);

    // 4b. 500 -> 600 -> 700 inside one conversion: 600 must be dropped.
    balance = 27'd500;
    @(posedge clk);
    #1;
    repeat (5) @(posedge clk);
    #1;
    balance = 27'd600;
    repeat (5) @(posedge clk);
    #1;
    balance = 27'd700;
    wait_done(40, edges, bc);
    check_result("t4b_first", 500);
    wait_done(40, edges, bc);
    check_result("t4b_second", 700);

    // 5. Stable balance: exactly one done over a long window, busy idle after.
    balance    = 27'd4242;
    dones      = 0;
    busy_after = 0;
    for (int i = 0; i < 240; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        dones++;
        check_result("t5", 4242);
      end
      if (dones > 0 && busy) busy_after++;
    end
    check_val("t5_done_count", dones, 64'd1);
    check_val("t5_busy_after", busy_after, 64'd0);

    // 6. Async reset at cnt=15, then a clean conversion of 98765.
    balance = 27'd98765;
    @(posedge clk);
    #1;
    repeat (15) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("t6_async_bcd", {28'd0, bcd}, 64'd0);
    check_val("t6_async_blank", {55'd0, blank}, {55'd0, 9'b111111110});
    check_val("t6_async_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_done(40, edges, bc);
    check_result("t6", 98765);
    check_val("t6_lit", {28'd0, bcd}, {28'd0, 36'h000098765});

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
